wb_pipe_reg: RTL
================

# wb_pipe_reg

Parametrised MEM/WB pipeline register for the Sirius core, replacing the fixed single-lane register between memory and write-back stages. Adds a valid/ready handshake backed by a 2-entry skid buffer, pipeline stall and flush, up to two parallel write lanes, and write filtering (r0 suppression, same-address lane collision). Sits between the memory stage and the register file write port(s).

## Interface
- REG_ADDR_W, 5, register address width
- DATA_W, 32, write data width
- NUM_LANES, 1, parallel write lanes, legal values 1 or 2
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold stage: blocks acceptance and consumption
- flush  in  1  synchronous discard of all buffered entries
- mem_valid  in  1  memory stage presents a bundle
- mem_ready  out  1  block can accept a bundle
- mem_wd  in  NUM_LANES*REG_ADDR_W  destination addresses, lane i at [i*REG_ADDR_W +: REG_ADDR_W]
- mem_wdata  in  NUM_LANES*DATA_W  write data, same packing
- mem_wreg  in  NUM_LANES  per-lane write enable
- wb_valid  out  1  bundle presented to write-back
- wb_ready  in  1  write-back consumes bundle
- wb_wd, wb_wdata, wb_wreg  out  packed as inputs  registered bundle to write-back
- occupancy  out  2  entries held, 0..2

## Operation
- Storage: main entry (drives wb_* directly from flops) and skid entry. States EMPTY (0), ONE (1), FULL (2); occupancy reflects state.
- accept = mem_valid & mem_ready & !stall & !flush; consume = wb_valid & wb_ready & !stall & !flush.
- mem_ready = registered !skid_valid; 1 in EMPTY/ONE, 0 in FULL. Not gated by stall combinationally (stall gates accept).
- EMPTY: accept -> bundle into main, ONE.
- ONE: accept & consume -> new bundle into main, stay ONE; accept only -> new bundle into skid, FULL; consume only -> EMPTY.
- FULL: consume -> skid moves to main, ONE; no consume -> hold.
- Write filtering at capture: lane wreg cleared if its wd == 0; if NUM_LANES=2, both lanes enabled with equal wd, lane 0 wreg cleared (lane 1 wins).
- wb_wreg bits are 0 whenever wb_valid=0.
- flush: next edge -> EMPTY, wb_valid=0, wb_wreg=0, mem_ready=1; priority over stall, accept, consume. wb_wd/wb_wdata hold.
- stall (no flush): all state and outputs hold.

## Timing
- Reset (async assert): wb_wd=0, wb_wdata=0, wb_wreg=0, wb_valid=0, mem_ready=1, occupancy=0.
- Latency: accept at edge N -> wb_valid and data visible after edge N, consumable at edge N+1.
- Throughput: 1 bundle/cycle when wb_ready held high.
- Back-pressure: mem_ready drops the cycle after entering FULL; rises the cycle after FULL->ONE.
- Reset asserted mid-operation: all entries lost immediately, no partial write-back.
- No combinational path from wb_ready to mem_ready.

## Configuration
- WB_HILO_EN defined: adds ports mem_whilo (in 1), mem_hi, mem_lo (in DATA_W), wb_whilo (out 1), wb_hi, wb_lo (out DATA_W); buffered in both entries alongside lanes; wb_whilo obeys same valid masking, flush and reset (all 0).
- Undefined: ports and storage absent; remaining behaviour unchanged.

## Test plan
- Reset: assert rst mid-stream with occupancy=2 -> all outputs 0, mem_ready=1, occupancy=0 without a clock edge.
- Streaming: wb_ready=1, 8 back-to-back bundles wd=1..8, wdata=0x100+i -> each appears one cycle later, in order, occupancy=1 throughout.
- Back-pressure: wb_ready=0 for 3 cycles with mem_valid=1 -> occupancy 1 then 2, mem_ready=0, no bundle lost/duplicated once wb_ready=1.
- Flush in FULL: flush=1 with stall=1 and mem_valid=1 -> next edge wb_valid=0, wb_wreg=0, occupancy=0, input bundle dropped.
- Filtering (NUM_LANES=2): lanes wd={3,3}, wreg={1,1}, wdata={0xA,0xB} -> wb_wreg=2'b10; lane wd=0, wreg=1 -> wb_wreg bit 0.
- WB_HILO_EN: mem_whilo=1, hi=0xDEAD, lo=0xBEEF -> next cycle wb_whilo=1, wb_hi=0xDEAD, wb_lo=0xBEEF; cleared by flush.

Source files
------------

// File: rtl/wb_pipe_reg.sv
// MEM/WB pipeline register with valid/ready handshake, 2-entry skid buffer,
// stall/flush and write filtering. Optional HI/LO transport: `define WB_HILO_EN.
module wb_pipe_reg #(
   parameter int REG_ADDR_W = 5,
   parameter int DATA_W     = 32,
   parameter int NUM_LANES  = 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            stall,
   input  logic                            flush,
   input  logic                            mem_valid,
   output logic                            mem_ready,
   input  logic [NUM_LANES*REG_ADDR_W-1:0] mem_wd,
   input  logic [NUM_LANES*DATA_W-1:0]     mem_wdata,
   input  logic [NUM_LANES-1:0]            mem_wreg,
   output logic                            wb_valid,
   input  logic                            wb_ready,
   output logic [NUM_LANES*REG_ADDR_W-1:0] wb_wd,
   output logic [NUM_LANES*DATA_W-1:0]     wb_wdata,
   output logic [NUM_LANES-1:0]            wb_wreg,
`ifdef WB_HILO_EN
   input  logic                            mem_whilo,
   input  logic [DATA_W-1:0]               mem_hi,
   input  logic [DATA_W-1:0]               mem_lo,
   output logic                            wb_whilo,
   output logic [DATA_W-1:0]               wb_hi,
   output logic [DATA_W-1:0]               wb_lo,
`endif
   output logic [1:0]                      occupancy
);

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   // Each entry splits into enable bits (masked when invalid or flushed)
   // and payload (left stale on flush, so wb_wd/wb_wdata hold).
`ifdef WB_HILO_EN
   localparam int EN_W = NUM_LANES + 1;
   localparam int PL_W = NUM_LANES*(REG_ADDR_W + DATA_W) + 2*DATA_W;
`else
   localparam int EN_W = NUM_LANES;
   localparam int PL_W = NUM_LANES*(REG_ADDR_W + DATA_W);
`endif

   logic [1:0]            state_q, state_d;
   logic                  wb_valid_q, wb_valid_d;
   logic                  mem_ready_q, mem_ready_d;
   logic [EN_W-1:0]       main_en_q, main_en_d, skid_en_q, skid_en_d;
   logic [PL_W-1:0]       main_pl_q, main_pl_d, skid_pl_q, skid_pl_d;

   logic                  accept;
   logic                  consume;
   logic [NUM_LANES-1:0]  r0_wreg;
   logic [NUM_LANES-1:0]  cap_wreg;
   logic [EN_W-1:0]       cap_en;
   logic [PL_W-1:0]       cap_pl;

   assign accept  = mem_valid & mem_ready_q & ~stall & ~flush;
   assign consume = wb_valid_q & wb_ready & ~stall & ~flush;

   // Writes to r0 are architecturally dead, so drop them at capture.
   always_comb begin
      for (int i = 0; i < NUM_LANES; i++) begin
         r0_wreg[i] = mem_wreg[i] & (mem_wd[i*REG_ADDR_W +: REG_ADDR_W] != '0);
      end
   end

   generate
      if (NUM_LANES == 2) begin : g_collide
         logic same_wd;
         assign same_wd  = (mem_wd[0 +: REG_ADDR_W] == mem_wd[REG_ADDR_W +: REG_ADDR_W]);
         // Younger lane 1 wins a same-register collision.
         assign cap_wreg = {r0_wreg[1], r0_wreg[0] & ~(r0_wreg[1] & same_wd)};
      end else begin : g_single
         assign cap_wreg = r0_wreg;
      end
   endgenerate

`ifdef WB_HILO_EN
   assign cap_en = {mem_whilo, cap_wreg};
   assign cap_pl = {mem_hi, mem_lo, mem_wd, mem_wdata};
`else
   assign cap_en = cap_wreg;
   assign cap_pl = {mem_wd, mem_wdata};
`endif

   always_comb begin
      // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
      state_d   = state_q;
      main_en_d = main_en_q;
      main_pl_d = main_pl_q;
      skid_en_d = skid_en_q;
      skid_pl_d = skid_pl_q;

      if (flush) begin
         state_d   = ST_EMPTY;
         main_en_d = '0;
         skid_en_d = '0;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  main_en_d = cap_en;
                  main_pl_d = cap_pl;
                  state_d   = ST_ONE;
               end
            end
            ST_ONE: begin
               if (accept && consume) begin
                  main_en_d = cap_en;
                  main_pl_d = cap_pl;
               end else if (accept) begin
                  skid_en_d = cap_en;
                  skid_pl_d = cap_pl;
                  state_d   = ST_FULL;
               end else if (consume) begin
                  main_en_d = '0;
                  state_d   = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (consume) begin
                  main_en_d = skid_en_q;
                  main_pl_d = skid_pl_q;
                  skid_en_d = '0;
                  state_d   = ST_ONE;
               end
            end
            default: begin
               main_en_d = '0;
               skid_en_d = '0;
               state_d   = ST_EMPTY;
            end
         endcase
      end

      // Handshake outputs are registered copies of the next state, which
      // keeps wb_ready off any combinational path to mem_ready.
      wb_valid_d  = (state_d != ST_EMPTY);
      mem_ready_d = (state_d != ST_FULL);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: payload flops are reset as well because wb_wd/wb_wdata must read 0 out of reset.
         state_q     <= ST_EMPTY;
         wb_valid_q  <= 1'b0;
         mem_ready_q <= 1'b1;
         main_en_q   <= '0;
         main_pl_q   <= '0;
         skid_en_q   <= '0;
         skid_pl_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q     <= state_d;
         wb_valid_q  <= wb_valid_d;
         mem_ready_q <= mem_ready_d;
         main_en_q   <= main_en_d;
         main_pl_q   <= main_pl_d;
         skid_en_q   <= skid_en_d;
         skid_pl_q   <= skid_pl_d;
      end
   end

   assign mem_ready = mem_ready_q;
   assign wb_valid  = wb_valid_q;
   assign occupancy = state_q;

`ifdef WB_HILO_EN
   assign {wb_whilo, wb_wreg}              = main_en_q;
   assign {wb_hi, wb_lo, wb_wd, wb_wdata}  = main_pl_q;
`else
   assign wb_wreg             = main_en_q;
   assign {wb_wd, wb_wdata}   = main_pl_q;
`endif

endmodule
